galaga_pixel_compositor: RTL and testbench
==========================================

GALAGA_PIXEL_COMPOSITOR -- requirements
Module: galaga_pixel_compositor

Interface
REQ-001 SHALL have parameter N_ENEMY, default 15, number of enemy objects.
REQ-002 SHALL have parameter N_EBULLET, default 31, number of enemy bullets.
REQ-003 SHALL have parameter N_PBULLET, default 15, number of player bullets.
REQ-004 SHALL have parameters X_W=10 and Y_W=9, the coordinate widths; each packed position is {y[Y_W-1:0], x[X_W-1:0]}, POS_W=X_W+Y_W.
REQ-005 SHALL have size parameters ENEMY_W=36, ENEMY_H=24, PLAYER_W=24, PLAYER_H=36, BULLET_W=4, BULLET_H=16, SCREEN_H=480.
REQ-006 i_clk  in  1  single clock; all logic on its rising edge.
REQ-007 i_rst  in  1  reset, synchronous, active-high.
REQ-008 i_pixelValid  in  1  qualifies i_n_PixelPos_x/y this cycle.
REQ-009 i_frameStart  in  1  one-cycle pulse marking the first pixel of a frame.
REQ-010 i_n_PixelPos_x  in  X_W  current pixel x; i_n_PixelPos_y  in  Y_W  current pixel y.
REQ-011 i_enemyState  in  N_ENEMY; i_enemyPosition  in  N_ENEMY*POS_W.
REQ-012 i_enemyBulletState  in  N_EBULLET; i_enemyBulletPosition  in  N_EBULLET*POS_W.
REQ-013 i_playerState  in  1; i_playerPosition  in  X_W  (player x; player top y fixed at SCREEN_H-PLAYER_H).
REQ-014 i_playerBulletState  in  N_PBULLET; i_playerBulletPosition  in  N_PBULLET*POS_W.
REQ-015 o_pixelState  out  3  colour code; o_pixelValid  out  1  qualifies o_pixelState.
REQ-016 o_enemyHit  out  N_ENEMY  per-enemy hit flags of last completed frame; o_playerHit  out  1; o_hitValid  out  1  one-cycle pulse when hit outputs update.

Function
REQ-017 Object i covers pixel (x,y) SHALL mean state[i]=1, x>=px, x<px+W, y>=py, y<py+H, with sums computed at X_W+1 / Y_W+1 bits (no wrap-around at right/bottom edge).
REQ-018 Player bullets SHALL use i_playerBulletPosition (not enemy positions) for coverage.
REQ-019 Stage 1 SHALL register: pixel valid, frameStart, per-enemy cover vector, OR of enemy-bullet cover, OR of player-bullet cover, player cover.
REQ-020 Stage 2 SHALL register o_pixelState by fixed priority: enemy 100 > enemy bullet 011 > player 001 > player bullet 010 > background 000.
REQ-021 o_pixelState/o_pixelValid SHALL appear exactly 2 cycles after the input pixel; one result per cycle, no stalls.
REQ-022 Inputs with i_pixelValid=0 SHALL yield o_pixelValid=0, o_pixelState=000, and no accumulator effect.
REQ-023 Accumulator bit acc[i] SHALL set on a valid pixel covered by enemy i and by any active player bullet.
REQ-024 Player accumulator SHALL set on a valid pixel covered by the player and by any active enemy or enemy bullet.
REQ-025 Accumulator bits SHALL be sticky until frame boundary.
REQ-026 When frameStart reaches stage 2: o_enemyHit<=acc, o_playerHit<=pacc, o_hitValid=1 for that cycle; acc/pacc then hold only the contribution of that same pixel (clear-and-set, new frame).
REQ-027 frameStart with pixelValid=0 SHALL still latch/clear; back-to-back frameStart SHALL latch an all-zero frame the second time.
REQ-028 o_enemyHit/o_playerHit SHALL hold between o_hitValid pulses.
REQ-029 Multiple overlapping objects of one class SHALL be OR-reduced; state bits of 0 SHALL never cover.

Reset
REQ-030 With i_rst=1 at a clock edge, all pipeline registers, accumulators, o_pixelState=000, o_pixelValid=0, o_enemyHit=0, o_playerHit=0, o_hitValid=0 next cycle.
REQ-031 Reset mid-frame SHALL discard in-flight pixels and partial accumulation; first o_hitValid after reset follows the next frameStart.

Verification
REQ-032 Enemy0 at (100,50), active; pixel (100,50) valid at cycle t -> o_pixelState=100, o_pixelValid=1 at t+2; pixel (136,50) -> 000.
REQ-033 Enemy0 at (100,50) and enemy bullet 3 at (110,55) both active; pixel (112,60) -> 100; enemy0 cleared -> 011.
REQ-034 Player x=1010, pixel (1020,460) -> 001; pixel (2,460) -> 000 (no wrap).
REQ-035 Player bullet 2 at (120,60) over enemy0 at (100,50); frame sweeps pixel (121,61); next frameStart -> o_hitValid pulse, o_enemyHit=15'h0001, o_playerHit=0; following frame without overlap -> o_enemyHit=0.
REQ-036 Enemy bullet at (10,450) over player x=8; assert i_rst for one cycle before frameStart -> next o_hitValid reports o_playerHit=0; repeat without reset -> o_playerHit=1.

Source files
------------

// File: rtl/galaga_pixel_compositor.sv
// galaga_pixel_compositor: two-stage sprite priority compositor with per-frame hit accumulation
module galaga_pixel_compositor #(
  parameter int N_ENEMY   = 15,
  parameter int N_EBULLET = 31,
  parameter int N_PBULLET = 15,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int ENEMY_W   = 36,
  parameter int ENEMY_H   = 24,
  parameter int PLAYER_W  = 24,
  parameter int PLAYER_H  = 36,
  parameter int BULLET_W  = 4,
  parameter int BULLET_H  = 16,
  parameter int SCREEN_H  = 480
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_pixelValid,
  input  logic                         i_frameStart,
  input  logic [X_W-1:0]               i_n_PixelPos_x,
  input  logic [Y_W-1:0]               i_n_PixelPos_y,
  input  logic [N_ENEMY-1:0]           i_enemyState,
  input  logic [N_ENEMY*(X_W+Y_W)-1:0]   i_enemyPosition,
  input  logic [N_EBULLET-1:0]         i_enemyBulletState,
  input  logic [N_EBULLET*(X_W+Y_W)-1:0] i_enemyBulletPosition,
  input  logic                         i_playerState,
  input  logic [X_W-1:0]               i_playerPosition,
  input  logic [N_PBULLET-1:0]         i_playerBulletState,
  input  logic [N_PBULLET*(X_W+Y_W)-1:0] i_playerBulletPosition,
  output logic [2:0]                   o_pixelState,
  output logic                         o_pixelValid,
  output logic [N_ENEMY-1:0]           o_enemyHit,
  output logic                         o_playerHit,
  output logic                         o_hitValid
);
  localparam int POS_W    = X_W + Y_W;
  localparam int PLAYER_Y = SCREEN_H - PLAYER_H;

  // One extra bit on the far edges so objects near the right/bottom border never wrap to 0.
  function automatic logic covers(input logic [X_W-1:0] x, input logic [X_W-1:0] ox,
                                  input logic [Y_W-1:0] y, input logic [Y_W-1:0] oy,
                                  input int w, input int h);
    covers = x >= ox && {1'b0, x} < {1'b0, ox} + (X_W+1)'(w)
          && y >= oy && {1'b0, y} < {1'b0, oy} + (Y_W+1)'(h);
  endfunction

  logic [N_ENEMY-1:0]   enemyCov;
  logic [N_EBULLET-1:0] eBulletCov;
  logic [N_PBULLET-1:0] pBulletCov;
  logic                 playerCov;

  for (genvar i = 0; i < N_ENEMY; i++) begin : g_enemy
    assign enemyCov[i] = i_enemyState[i] & covers(i_n_PixelPos_x, i_enemyPosition[i*POS_W +: X_W],
      i_n_PixelPos_y, i_enemyPosition[i*POS_W+X_W +: Y_W], ENEMY_W, ENEMY_H);
  end
  for (genvar i = 0; i < N_EBULLET; i++) begin : g_ebullet
    assign eBulletCov[i] = i_enemyBulletState[i] & covers(i_n_PixelPos_x, i_enemyBulletPosition[i*POS_W +: X_W],
      i_n_PixelPos_y, i_enemyBulletPosition[i*POS_W+X_W +: Y_W], BULLET_W, BULLET_H);
  end
  for (genvar i = 0; i < N_PBULLET; i++) begin : g_pbullet
    assign pBulletCov[i] = i_playerBulletState[i] & covers(i_n_PixelPos_x, i_playerBulletPosition[i*POS_W +: X_W],
      i_n_PixelPos_y, i_playerBulletPosition[i*POS_W+X_W +: Y_W], BULLET_W, BULLET_H);
  end
  assign playerCov = i_playerState & covers(i_n_PixelPos_x, i_playerPosition,
    i_n_PixelPos_y, Y_W'(PLAYER_Y), PLAYER_W, PLAYER_H);

  logic               s1Valid, s1Frame, s1EBullet, s1PBullet, s1Player;
  logic [N_ENEMY-1:0] s1Enemy, acc, accNext;
  logic               pacc, paccNext;
  logic [2:0]         pixNext;

  // Covers are zeroed for invalid pixels so stage 2 needs no further qualification.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1Valid   <= 1'b0;
      s1Frame   <= 1'b0;
      s1Enemy   <= '0;
      s1EBullet <= 1'b0;
      s1PBullet <= 1'b0;
      s1Player  <= 1'b0;
    end else begin
      s1Valid   <= i_pixelValid;
      s1Frame   <= i_frameStart;
      s1Enemy   <= i_pixelValid ? enemyCov : '0;
      s1EBullet <= i_pixelValid & |eBulletCov;
      s1PBullet <= i_pixelValid & |pBulletCov;
      s1Player  <= i_pixelValid & playerCov;
    end
  end

  always_comb begin
    accNext  = s1Enemy & {N_ENEMY{s1PBullet}};
    paccNext = s1Player & (|s1Enemy | s1EBullet);
    pixNext  = |s1Enemy ? 3'b100 : s1EBullet ? 3'b011 : s1Player ? 3'b001 : s1PBullet ? 3'b010 : 3'b000;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pixelState <= 3'b000;
      o_pixelValid <= 1'b0;
      o_hitValid   <= 1'b0;
      o_enemyHit   <= '0;
      o_playerHit  <= 1'b0;
      acc          <= '0;
      pacc         <= 1'b0;
    end else begin
      o_pixelState <= pixNext;
      o_pixelValid <= s1Valid;
      o_hitValid   <= s1Frame;
      acc          <= s1Frame ? accNext : acc | accNext;
      pacc         <= s1Frame ? paccNext : pacc | paccNext;
      if (s1Frame) begin
        o_enemyHit  <= acc;
        o_playerHit <= pacc;
      end
    end
  end
endmodule

// File: tb/tb_galaga_pixel_compositor.sv
// tb_galaga_pixel_compositor: directed spec scenarios plus randomized sweep against a geometric reference model
module tb_galaga_pixel_compositor;
  localparam int NE = 15, NEB = 31, NPB = 15, POS_W = 19;

  logic clk = 1'b0, rst = 1'b1, pv = 1'b0, fs = 1'b0;
  logic [9:0] px = '0;
  logic [8:0] py = '0;
  logic [NE-1:0] eSt = '0;
  logic [NE*POS_W-1:0] ePos = '0;
  logic [NEB-1:0] ebSt = '0;
  logic [NEB*POS_W-1:0] ebPos = '0;
  logic plSt = 1'b0;
  logic [9:0] plX = '0;
  logic [NPB-1:0] pbSt = '0;
  logic [NPB*POS_W-1:0] pbPos = '0;
  logic [2:0] oState;
  logic oValid, oPHit, oHValid;
  logic [NE-1:0] oEHit;

  galaga_pixel_compositor dut (
    .i_clk(clk), .i_rst(rst), .i_pixelValid(pv), .i_frameStart(fs),
    .i_n_PixelPos_x(px), .i_n_PixelPos_y(py),
    .i_enemyState(eSt), .i_enemyPosition(ePos),
    .i_enemyBulletState(ebSt), .i_enemyBulletPosition(ebPos),
    .i_playerState(plSt), .i_playerPosition(plX),
    .i_playerBulletState(pbSt), .i_playerBulletPosition(pbPos),
    .o_pixelState(oState), .o_pixelValid(oValid),
    .o_enemyHit(oEHit), .o_playerHit(oPHit), .o_hitValid(oHValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v;
    logic [2:0] st;
    logic hv;
    logic [NE-1:0] eh;
    logic ph;
  } exp_t;

  exp_t q[$];
  logic [NE-1:0] mAcc, mLastE;
  logic mPacc, mLastP;
  int total = 0, bad = 0;

  function automatic bit cov(int x, int y, int ox, int oy, int w, int h);
    return x >= ox && x < ox + w && y >= oy && y < oy + h;
  endfunction

  // Model: what the screen shows at (x,y) and which collisions that pixel proves.
  task automatic pix(input int x, input int y, input bit v, input bit f);
    exp_t e;
    bit en, eb, pb, pl, pc;
    logic [NE-1:0] ec;
    px = x[9:0]; py = y[8:0]; pv = v; fs = f;
    en = 0; eb = 0; pb = 0; ec = '0;
    for (int i = 0; i < NE; i++) begin
      ec[i] = v && eSt[i] && cov(x, y, int'(ePos[i*POS_W +: 10]), int'(ePos[i*POS_W+10 +: 9]), 36, 24);
      en |= ec[i];
    end
    for (int i = 0; i < NEB; i++)
      eb |= v && ebSt[i] && cov(x, y, int'(ebPos[i*POS_W +: 10]), int'(ebPos[i*POS_W+10 +: 9]), 4, 16);
    for (int i = 0; i < NPB; i++)
      pb |= v && pbSt[i] && cov(x, y, int'(pbPos[i*POS_W +: 10]), int'(pbPos[i*POS_W+10 +: 9]), 4, 16);
    pl = v && plSt && cov(x, y, int'(plX), 480 - 36, 24, 36);
    if (!pb) ec = '0;
    pc = pl && (en || eb);
    e.v = v;
    e.st = en ? 3'd4 : eb ? 3'd3 : pl ? 3'd1 : pb ? 3'd2 : 3'd0;
    e.hv = f;
    if (f) begin
      mLastE = mAcc; mLastP = mPacc; mAcc = ec; mPacc = pc;
    end else begin
      mAcc |= ec; mPacc |= pc;
    end
    e.eh = mLastE; e.ph = mLastP;
    q.push_back(e);
    if (q.size() > 2) q.delete(0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    exp_t z;
    rst = 1; pv = 0; fs = 0;
    @(posedge clk); #1;
    rst = 0;
    mAcc = '0; mPacc = 0; mLastE = '0; mLastP = 0;
    z.v = 0; z.st = 0; z.hv = 0; z.eh = '0; z.ph = 0;
    q.delete();
    q.push_back(z);
  endtask

  task automatic clear_objs;
    eSt = '0; ebSt = '0; pbSt = '0; plSt = 0; plX = '0;
    ePos = '0; ebPos = '0; pbPos = '0;
  endtask

  task automatic set_enemy(input int i, input bit s, input int x, input int y);
    eSt[i] = s; ePos[i*POS_W +: POS_W] = {y[8:0], x[9:0]};
  endtask
  task automatic set_ebullet(input int i, input bit s, input int x, input int y);
    ebSt[i] = s; ebPos[i*POS_W +: POS_W] = {y[8:0], x[9:0]};
  endtask
  task automatic set_pbullet(input int i, input bit s, input int x, input int y);
    pbSt[i] = s; pbPos[i*POS_W +: POS_W] = {y[8:0], x[9:0]};
  endtask

  task automatic test_reset;
    clear_objs;
    set_enemy(0, 1, 100, 50);
    set_pbullet(2, 1, 120, 60);
    pix(121, 61, 1, 1);
    pix(121, 61, 1, 1);
    do_reset;
    total++;
    if (oState !== 3'b000 || oValid !== 1'b0 || oHValid !== 1'b0 || oEHit !== '0 || oPHit !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got st=%b v=%b hv=%b eh=%h ph=%b want all zero", oState, oValid, oHValid, oEHit, oPHit);
    end
    pix(0, 0, 0, 0);
    total++;
    if (oValid !== 1'b0 || oHValid !== 1'b0 || oState !== 3'b000) begin
      bad++; $display("FAIL reset_flush got st=%b v=%b hv=%b want 000/0/0", oState, oValid, oHValid);
    end
  endtask

  task automatic test_enemy;
    do_reset; clear_objs;
    set_enemy(0, 1, 100, 50);
    pix(100, 50, 1, 0);
    pix(136, 50, 1, 0);
    total++;
    if (oState !== 3'b100 || oValid !== 1'b1) begin
      bad++; $display("FAIL enemy_corner got st=%b v=%b want 100/1", oState, oValid);
    end
    pix(0, 0, 0, 0);
    total++;
    if (oState !== 3'b000 || oValid !== 1'b1) begin
      bad++; $display("FAIL enemy_right_edge got st=%b v=%b want 000/1", oState, oValid);
    end
    pix(100, 50, 0, 0);
    total++;
    if (oState !== 3'b000 || oValid !== 1'b0) begin
      bad++; $display("FAIL idle_pixel got st=%b v=%b want 000/0", oState, oValid);
    end
    pix(0, 0, 0, 0);
    total++;
    if (oState !== 3'b000 || oValid !== 1'b0) begin
      bad++; $display("FAIL invalid_covered got st=%b v=%b want 000/0", oState, oValid);
    end
  endtask

  task automatic test_priority;
    do_reset; clear_objs;
    set_enemy(0, 1, 100, 50);
    set_ebullet(3, 1, 110, 55);
    pix(112, 60, 1, 0);
    set_enemy(0, 0, 100, 50);
    pix(112, 60, 1, 0);
    total++;
    if (oState !== 3'b100) begin
      bad++; $display("FAIL enemy_over_ebullet got %b want 100", oState);
    end
    set_pbullet(2, 1, 120, 60);
    pix(121, 61, 1, 0);
    total++;
    if (oState !== 3'b011) begin
      bad++; $display("FAIL ebullet_only got %b want 011", oState);
    end
    pix(0, 0, 0, 0);
    total++;
    if (oState !== 3'b010) begin
      bad++; $display("FAIL pbullet_only got %b want 010", oState);
    end
  endtask

  task automatic test_player;
    do_reset; clear_objs;
    plSt = 1; plX = 10'd1010;
    pix(1020, 460, 1, 0);
    pix(2, 460, 1, 0);
    total++;
    if (oState !== 3'b001) begin
      bad++; $display("FAIL player_right_edge got %b want 001", oState);
    end
    set_pbullet(1, 1, 1012, 444);
    pix(1013, 450, 1, 0);
    total++;
    if (oState !== 3'b000) begin
      bad++; $display("FAIL player_no_wrap got %b want 000", oState);
    end
    pix(0, 0, 0, 0);
    total++;
    if (oState !== 3'b001) begin
      bad++; $display("FAIL player_over_pbullet got %b want 001", oState);
    end
  endtask

  task automatic test_enemy_hit;
    do_reset; clear_objs;
    set_enemy(0, 1, 100, 50);
    set_pbullet(2, 1, 120, 60);
    pix(0, 0, 1, 1);
    pix(121, 61, 1, 0);
    pix(0, 0, 1, 1);
    total++;
    if (oState !== 3'b100) begin
      bad++; $display("FAIL hit_pixel got %b want 100", oState);
    end
    pix(0, 0, 0, 0);
    total++;
    if (oHValid !== 1'b1 || oEHit !== 15'h0001 || oPHit !== 1'b0) begin
      bad++; $display("FAIL enemy_hit_report got hv=%b eh=%h ph=%b want 1/0001/0", oHValid, oEHit, oPHit);
    end
    pix(5, 5, 1, 0);
    total++;
    if (oHValid !== 1'b0 || oEHit !== 15'h0001) begin
      bad++; $display("FAIL enemy_hit_hold got hv=%b eh=%h want 0/0001", oHValid, oEHit);
    end
    pix(0, 0, 1, 1);
    pix(0, 0, 0, 0);
    total++;
    if (oHValid !== 1'b1 || oEHit !== 15'h0000) begin
      bad++; $display("FAIL enemy_hit_next_frame got hv=%b eh=%h want 1/0000", oHValid, oEHit);
    end
  endtask

  task automatic test_player_hit_reset;
    do_reset; clear_objs;
    set_ebullet(5, 1, 10, 450);
    plSt = 1; plX = 10'd8;
    pix(0, 0, 1, 1);
    pix(11, 455, 1, 0);
    pix(0, 0, 0, 0);
    total++;
    if (oState !== 3'b011) begin
      bad++; $display("FAIL ebullet_over_player got %b want 011", oState);
    end
    do_reset;
    pix(0, 0, 1, 1);
    pix(0, 0, 0, 0);
    total++;
    if (oHValid !== 1'b1 || oPHit !== 1'b0) begin
      bad++; $display("FAIL player_hit_after_reset got hv=%b ph=%b want 1/0", oHValid, oPHit);
    end
    pix(11, 455, 1, 0);
    pix(0, 0, 1, 1);
    pix(0, 0, 0, 0);
    total++;
    if (oHValid !== 1'b1 || oPHit !== 1'b1) begin
      bad++; $display("FAIL player_hit got hv=%b ph=%b want 1/1", oHValid, oPHit);
    end
  endtask

  task automatic test_back_to_back;
    do_reset; clear_objs;
    set_enemy(0, 1, 100, 50);
    set_pbullet(2, 1, 120, 60);
    pix(121, 61, 1, 1);
    pix(0, 0, 0, 1);
    pix(0, 0, 0, 1);
    total++;
    if (oHValid !== 1'b1 || oEHit !== 15'h0001) begin
      bad++; $display("FAIL frame_start_pixel_counts got hv=%b eh=%h want 1/0001", oHValid, oEHit);
    end
    pix(0, 0, 0, 0);
    total++;
    if (oHValid !== 1'b1 || oEHit !== 15'h0000) begin
      bad++; $display("FAIL back_to_back_empty got hv=%b eh=%h want 1/0000", oHValid, oEHit);
    end
  endtask

  function automatic int rx();
    return $urandom_range(0, 3) == 0 ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 230));
  endfunction
  function automatic int ry();
    return $urandom_range(0, 1) == 0 ? int'($urandom_range(0, 110)) : int'($urandom_range(430, 511));
  endfunction

  task automatic rand_objs;
    for (int i = 0; i < NE; i++) set_enemy(i, $urandom_range(0, 2) == 0, rx(), ry());
    for (int i = 0; i < NEB; i++) set_ebullet(i, $urandom_range(0, 2) == 0, rx(), ry());
    for (int i = 0; i < NPB; i++) set_pbullet(i, $urandom_range(0, 2) == 0, rx(), ry());
    plSt = $urandom_range(0, 3) != 0;
    plX = 10'(rx());
  endtask

  task automatic test_random;
    int x, y;
    do_reset;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) rand_objs;
      if (c == 1500) do_reset;
      x = $urandom_range(0, 4) == 0 ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 255));
      y = ry();
      pix(x, y, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      total++;
      if (oValid !== q[0].v || oState !== q[0].st) begin
        bad++; $display("FAIL rand_pixel c=%0d got v=%b st=%b want v=%b st=%b", c, oValid, oState, q[0].v, q[0].st);
      end
      total++;
      if (oHValid !== q[0].hv || oEHit !== q[0].eh || oPHit !== q[0].ph) begin
        bad++; $display("FAIL rand_hits c=%0d got hv=%b eh=%h ph=%b want hv=%b eh=%h ph=%b",
                        c, oHValid, oEHit, oPHit, q[0].hv, q[0].eh, q[0].ph);
      end
    end
  endtask

  initial begin
    mAcc = '0; mPacc = 0; mLastE = '0; mLastP = 0;
    @(posedge clk); #1;
    test_reset;
    test_enemy;
    test_priority;
    test_player;
    test_enemy_hit;
    test_player_hit_reset;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
